// File: rtl/emulador_sensor_ultrassonico_if.sv
// Trigger/echo link between a ranging front end (master) and the HC-SR04 emulator (slave).
interface emulador_sensor_ultrassonico_if;
    logic       habilita;
    logic       trigger;
    logic [8:0] distancia_cm;
    logic       echo;
    logic       ocupado;
    logic [3:0] db_estado;

    modport master (
        output habilita, trigger, distancia_cm,
        input  echo, ocupado, db_estado
    );

    modport slave (
        input  habilita, trigger, distancia_cm,
        output echo, ocupado, db_estado
    );
endinterface

// File: rtl/emulador_sensor_ultrassonico.sv
// HC-SR04 responder: validates a trigger pulse and answers with an echo whose
// width encodes the programmed distance, then holds off before re-arming.
module emulador_sensor_ultrassonico #(
    parameter int unsigned TRIG_MIN_CYCLES = 500,
    parameter int unsigned SETUP_CYCLES    = 10000,
    parameter int unsigned CYCLES_PER_CM   = 2941,
    parameter int unsigned DIST_MIN        = 2,
    parameter int unsigned DIST_MAX        = 400,
    parameter int unsigned TIMEOUT_CYCLES  = 1900000,
    parameter int unsigned HOLDOFF_CYCLES  = 500000
) (
    input  logic                           clock,
    input  logic                           reset,
    emulador_sensor_ultrassonico_if.slave  sensor
);

    localparam int unsigned DW      = 9;
    localparam int unsigned TRIG_W  = $clog2(TRIG_MIN_CYCLES + 1);
    localparam int unsigned TMR_MAX = (SETUP_CYCLES > HOLDOFF_CYCLES) ? SETUP_CYCLES : HOLDOFF_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned PRE_W   = $clog2(CYCLES_PER_CM + 1);
    localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        MEDE_TRIG = 4'd1,
        DISPARO   = 4'd2,
        ECO       = 4'd3,
        REPOUSO   = 4'd4
    } estado_t;

    estado_t           state_q;
    logic [1:0]        sync_q;
    logic              trig_prev_q;
    logic [TRIG_W-1:0] larg_q;
    logic [TMR_W-1:0]  tmr_q;
    logic [PRE_W-1:0]  pre_q;
    logic [DW-1:0]     cm_q;
    logic [TO_W-1:0]   to_q;
    logic [DW-1:0]     dist_q;
    logic              fora_q;
    logic              echo_q;
    logic              ocupado_q;

    logic          trig_s_c;
    logic          rise_c;
    logic          fall_c;
    logic [DW-1:0] dist_c;
    logic          fora_c;
    logic          eco_fim_c;

    // Edge detection on the synchronized trigger.
    assign trig_s_c = sync_q[1];
    assign rise_c   = trig_s_c & ~trig_prev_q;
    assign fall_c   = ~trig_s_c & trig_prev_q;

    // Clamp below DIST_MIN; anything above DIST_MAX becomes a timeout echo.
    assign dist_c = (sensor.distancia_cm < DW'(DIST_MIN)) ? DW'(DIST_MIN) : sensor.distancia_cm;
    assign fora_c = (sensor.distancia_cm > DW'(DIST_MAX));

    assign eco_fim_c = fora_q ? (to_q == '0) : ((pre_q == '0) && (cm_q == '0));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= INICIAL;
            sync_q      <= '0;
            trig_prev_q <= 1'b0;
            larg_q      <= '0;
            tmr_q       <= '0;
            pre_q       <= '0;
            cm_q        <= '0;
            to_q        <= '0;
            dist_q      <= '0;
            fora_q      <= 1'b0;
            echo_q      <= 1'b0;
            ocupado_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], sensor.trigger};
            trig_prev_q <= trig_s_c;

            case (state_q)
                INICIAL: begin
                    if (rise_c && sensor.habilita) begin
                        state_q   <= MEDE_TRIG;
                        larg_q    <= TRIG_W'(1);
                        ocupado_q <= 1'b1;
                    end
                end

                MEDE_TRIG: begin
                    if (fall_c) begin
                        if (larg_q >= TRIG_W'(TRIG_MIN_CYCLES)) begin
                            state_q <= DISPARO;
                            dist_q  <= dist_c;
                            fora_q  <= fora_c;
                            tmr_q   <= TMR_W'(SETUP_CYCLES - 1);
                        end else begin
                            state_q   <= INICIAL;
                            ocupado_q <= 1'b0;
                        end
                    end else if (trig_s_c && (larg_q < TRIG_W'(TRIG_MIN_CYCLES))) begin
                        larg_q <= larg_q + TRIG_W'(1);
                    end
                end

                DISPARO: begin
                    if (tmr_q == '0) begin
                        state_q <= ECO;
                        echo_q  <= 1'b1;
                        pre_q   <= PRE_W'(CYCLES_PER_CM - 1);
                        cm_q    <= dist_q - DW'(1);
                        to_q    <= TO_W'(TIMEOUT_CYCLES - 1);
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end

                ECO: begin
                    if (eco_fim_c) begin
                        state_q <= REPOUSO;
                        echo_q  <= 1'b0;
                        tmr_q   <= TMR_W'(HOLDOFF_CYCLES - 1);
                    end else if (fora_q) begin
                        to_q <= to_q - TO_W'(1);
                    end else if (pre_q == '0) begin
                        pre_q <= PRE_W'(CYCLES_PER_CM - 1);
                        cm_q  <= cm_q - DW'(1);
                    end else begin
                        pre_q <= pre_q - PRE_W'(1);
                    end
                end

                REPOUSO: begin
                    if (tmr_q == '0) begin
                        state_q   <= INICIAL;
                        ocupado_q <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end

                default: begin
                    state_q   <= INICIAL;
                    echo_q    <= 1'b0;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    assign sensor.echo      = echo_q;
    assign sensor.ocupado   = ocupado_q;
    assign sensor.db_estado = state_q;

endmodule

// File: tb/tb_emulador_sensor_ultrassonico.sv
// Directed bench for the HC-SR04 emulator using the reduced test-plan timing.
module tb_emulador_sensor_ultrassonico;

    localparam int unsigned TRIG_MIN = 10;
    localparam int unsigned SETUP    = 20;
    localparam int unsigned CPC      = 5;
    localparam int unsigned TIMEOUT  = 3000;
    localparam int unsigned HOLDOFF  = 50;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    emulador_sensor_ultrassonico_if sif ();

    emulador_sensor_ultrassonico #(
        .TRIG_MIN_CYCLES(TRIG_MIN),
        .SETUP_CYCLES   (SETUP),
        .CYCLES_PER_CM  (CPC),
        .DIST_MIN       (2),
        .DIST_MAX       (400),
        .TIMEOUT_CYCLES (TIMEOUT),
        .HOLDOFF_CYCLES (HOLDOFF)
    ) dut (
        .clock (clock),
        .reset (reset),
        .sensor(sif.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    int          o_rises, o_echo_cyc, o_disp, o_rep, o_bad, o_lat;
    int          o_first_disp, o_first_echo, o_first_rep;
    logic [23:0] o_seq;
    logic [3:0]  o_final;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode: 0 plain, 1 extra pulse during ECO, 2 trigger raised in REPOUSO and held,
    //       3 distancia_cm changed to 300 during DISPARO.
    task automatic txn(input int w1, input logic hab, input logic [8:0] d,
                       input int mode, input int budget);
        logic [3:0] st, prev_st;
        logic       prev_echo, trig;
        o_rises = 0; o_echo_cyc = 0; o_disp = 0; o_rep = 0; o_bad = 0;
        o_first_disp = -1; o_first_echo = -1; o_first_rep = -1;
        prev_st   = sif.db_estado;
        prev_echo = sif.echo;
        st        = prev_st;
        o_seq     = {20'h0, prev_st};
        sif.habilita     = hab;
        sif.distancia_cm = d;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            st = sif.db_estado;
            if (st != prev_st) o_seq = {o_seq[19:0], st};
            if (st == 4'd2) begin o_disp++; if (o_first_disp < 0) o_first_disp = i; end
            if (st == 4'd4) begin o_rep++;  if (o_first_rep  < 0) o_first_rep  = i; end
            if (sif.echo) begin
                o_echo_cyc++;
                if (!prev_echo) begin
                    o_rises++;
                    if (o_first_echo < 0) o_first_echo = i;
                end
            end
            if (sif.echo !== (st == 4'd3)) o_bad++;
            prev_st   = st;
            prev_echo = sif.echo;

            trig = (i >= 5) && (i < 5 + w1);
            if (mode == 1 && o_first_echo >= 0 && i >= o_first_echo + 10 && i < o_first_echo + 22) trig = 1'b1;
            if (mode == 2 && o_first_rep >= 0 && i >= o_first_rep + 5) trig = 1'b1;
            if (mode == 3 && o_first_disp >= 0 && i == o_first_disp + 5) sif.distancia_cm = 9'd300;
            sif.trigger = trig;
        end
        o_final = st;
        o_lat   = o_first_echo - o_first_disp;
    endtask

    initial begin
        bit got;
        reset            = 1'b0;
        sif.habilita     = 1'b1;
        sif.trigger      = 1'b0;
        sif.distancia_cm = 9'd37;
        #23;
        chk("rst_echo",    int'(sif.echo),      0);
        chk("rst_ocupado", int'(sif.ocupado),   0);
        chk("rst_estado",  int'(sif.db_estado), 0);
        @(negedge clock);
        reset = 1'b1;

        // Nominal transaction, d=37.
        txn(12, 1'b1, 9'd37, 0, 320);
        chk("nom_rises",   o_rises,    1);
        chk("nom_lat",     o_lat,      int'(SETUP));
        chk("nom_width",   o_echo_cyc, 185);
        chk("nom_disp",    o_disp,     int'(SETUP));
        chk("nom_rep",     o_rep,      int'(HOLDOFF));
        chk("nom_seq",     int'(o_seq), 24'h012340);
        chk("nom_echo_eq", o_bad,      0);
        chk("nom_final",   int'(o_final), 0);

        // Runt trigger rejected, minimum width accepted.
        txn(9, 1'b1, 9'd37, 0, 320);
        chk("runt_rises", o_rises,     0);
        chk("runt_seq",   int'(o_seq), 12'h010);
        txn(10, 1'b1, 9'd37, 0, 320);
        chk("min_rises", o_rises,    1);
        chk("min_width", o_echo_cyc, 185);

        // Distance boundaries.
        txn(12, 1'b1, 9'd0, 0, 150);
        chk("d0_width", o_echo_cyc, 10);
        txn(12, 1'b1, 9'd400, 0, 2150);
        chk("d400_width", o_echo_cyc, 2000);
        txn(12, 1'b1, 9'd401, 0, 3150);
        chk("d401_width", o_echo_cyc, int'(TIMEOUT));
        txn(12, 1'b1, 9'd511, 0, 3150);
        chk("d511_width", o_echo_cyc, int'(TIMEOUT));
        chk("d511_eq",    o_bad,      0);

        // Retriggers ignored; held trigger needs a fresh edge.
        txn(12, 1'b1, 9'd37, 1, 320);
        chk("reeco_rises", o_rises,    1);
        chk("reeco_width", o_echo_cyc, 185);
        txn(12, 1'b1, 9'd37, 2, 400);
        chk("rerep_rises", o_rises,       1);
        chk("rerep_final", int'(o_final), 0);
        txn(12, 1'b1, 9'd37, 0, 320);
        chk("fresh_rises", o_rises,    1);
        chk("fresh_width", o_echo_cyc, 185);

        // habilita low ignores triggers; late distance change is not seen.
        txn(12, 1'b0, 9'd37, 0, 320);
        chk("hab0_rises", o_rises,     0);
        chk("hab0_seq",   int'(o_seq), 0);
        txn(12, 1'b1, 9'd20, 3, 320);
        chk("dchg_width", o_echo_cyc, 100);

        // Asynchronous reset in the middle of ECO, d=100.
        sif.habilita     = 1'b1;
        sif.distancia_cm = 9'd100;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            sif.trigger = 1'b1;
        end
        @(negedge clock);
        sif.trigger = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clock);
            got = sif.echo;
        end
        chk("mid_echo_up", int'(got), 1);
        repeat (50) @(negedge clock);
        chk("mid_estado_eco", int'(sif.db_estado), 3);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_echo",    int'(sif.echo),      0);
        chk("mid_rst_ocupado", int'(sif.ocupado),   0);
        chk("mid_rst_estado",  int'(sif.db_estado), 0);
        @(negedge clock);
        reset = 1'b1;
        txn(0, 1'b1, 9'd100, 0, 200);
        chk("post_rst_rises", o_rises,     0);
        chk("post_rst_seq",   int'(o_seq), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
